// File: rtl/alu_seq_arbiter_pkg.sv
// Shared types and constants for the two-requester sequential ALU arbiter.
package alu_seq_arbiter_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FLAG_W  = 5;

  localparam int unsigned FLAG_V = 4;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_P = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_CMP  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Captured request: owner, opcode and operands.
  typedef struct packed {
    logic              id;
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } txn_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/alu_seq_arbiter_cla.sv
// 16-bit carry-look-ahead adder: 4-bit lookahead groups, group carries chained.
module alu_seq_arbiter_cla
  import alu_seq_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              cout_o
);

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W:0]   c;

  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    c = '0;
    for (int k = 0; k < 16; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
    sum_o  = p ^ c[DATA_W-1:0];
    cout_o = c[DATA_W];
  end

endmodule

// File: rtl/alu_seq_arbiter.sv
// Round-robin arbiter for two requesters sharing one adder; SUB/CMP take a
// second pass that adds the +1 of the two's complement.
module alu_seq_arbiter
  import alu_seq_arbiter_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  input  logic [NUM_REQ*N-1:0]   req_a,
  input  logic [NUM_REQ*N-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [N-1:0]           rsp_result,
  output logic [FLAG_W-1:0]      rsp_flags
);

  state_e            state_q, state_d;
  txn_t              txn_q, txn_d;
  logic              rr_q, rr_d;
  logic              live_q, live_d;
  logic [N-1:0]      acc_q, acc_d;
  logic              c1_q, c1_d, c2_q, c2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [N-1:0]      rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

  logic [N-1:0]      add_a_c, add_b_c, add_sum_c;
  logic              add_cout_c;
  logic              grant_c;
  logic              is_sub_c;
  logic              b_msb_c;
  logic [FLAG_W-1:0] flags_c;

  alu_seq_arbiter_cla u_cla (
    .a_i    (add_a_c),
    .b_i    (add_b_c),
    .sum_o  (add_sum_c),
    .cout_o (add_cout_c)
  );

  // Next-state, adder operand steering and response assembly.
  always_comb begin
    state_d      = state_q;
    txn_d        = txn_q;
    rr_d         = rr_q;
    live_d       = 1'b1;
    acc_d        = acc_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    req_ready    = '0;
    add_a_c      = txn_q.a;
    add_b_c      = '0;

    grant_c  = (&req_valid) ? rr_q : req_valid[1];
    is_sub_c = (txn_q.op == OP_SUB) || (txn_q.op == OP_CMP);
    // PASS adds zero, so its overflow term must see a zero B sign.
    b_msb_c  = (txn_q.op == OP_PASS) ? 1'b0 : txn_q.b[N-1];

    flags_c         = '0;
    flags_c[FLAG_V] = is_sub_c ? ((txn_q.a[N-1] ^ b_msb_c) & (acc_q[N-1] ^ txn_q.a[N-1]))
                               : (~(txn_q.a[N-1] ^ b_msb_c) & (acc_q[N-1] ^ txn_q.a[N-1]));
    flags_c[FLAG_C] = c1_q | c2_q;
    flags_c[FLAG_N] = acc_q[N-1];
    flags_c[FLAG_Z] = (acc_q == '0);
    flags_c[FLAG_P] = even_parity(acc_q);

    case (state_q)
      ST_IDLE: begin
        if (live_q && (|req_valid)) begin
          req_ready[grant_c] = 1'b1;
          txn_d.id = grant_c;
          txn_d.op = grant_c ? op_e'(req_op[3:2]) : op_e'(req_op[1:0]);
          txn_d.a  = grant_c ? req_a[2*N-1:N] : req_a[N-1:0];
          txn_d.b  = grant_c ? req_b[2*N-1:N] : req_b[N-1:0];
          rr_d     = ~grant_c;
          c2_d     = 1'b0;
          state_d  = ST_PASS1;
        end
      end
      ST_PASS1: begin
        case (txn_q.op)
          OP_ADD:         add_b_c = txn_q.b;
          OP_SUB, OP_CMP: add_b_c = ~txn_q.b;
          OP_PASS:        add_b_c = '0;
        endcase
        acc_d   = add_sum_c;
        c1_d    = add_cout_c;
        state_d = is_sub_c ? ST_PASS2 : ST_RESP;
      end
      ST_PASS2: begin
        add_a_c = acc_q;
        add_b_c = N'(1);
        acc_d   = add_sum_c;
        c2_d    = add_cout_c;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // First RESP cycle loads the output registers; later cycles wait for the consumer.
        if (!rsp_valid_q) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = txn_q.id;
          rsp_result_d = (txn_q.op == OP_CMP) ? txn_q.a : acc_q;
          rsp_flags_d  = flags_c;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      txn_q        <= '0;
      rr_q         <= 1'b0;
      live_q       <= 1'b0;
      acc_q        <= '0;
      c1_q         <= 1'b0;
      c2_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_d;
      rr_q         <= rr_d;
      live_q       <= live_d;
      acc_q        <= acc_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Self-checking bench for alu_seq_arbiter: directed cases then randomized traffic
// against an arithmetic reference model.
module tb_alu_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  logic [1:0]  pend;
  logic [1:0]  p_op [2];
  logic [15:0] p_a  [2];
  logic [15:0] p_b  [2];
  int          rr_m;

  always #5 clk = ~clk;

  alu_seq_arbiter #(.N(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide/signed arithmetic; flags {V,C,N,Z,P}.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [4:0] f, output int lat);
    int          sa, sb, s;
    logic [16:0] w;
    logic [15:0] fv;
    logic        v, c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'b00: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0]; fv = r; c = w[16];
        s = sa + sb; v = (s > 32767) || (s < -32768);
        lat = 2;
      end
      2'b11: begin
        r = a; fv = a; c = 1'b0; v = 1'b0; lat = 2;
      end
      default: begin
        fv = a - b;
        r  = (op == 2'b10) ? a : fv;
        c  = (a >= b);
        s  = sa - sb; v = (s > 32767) || (s < -32768);
        lat = 3;
      end
    endcase
    f = {v, c, fv[15], (fv == 16'h0000), ~^fv};
  endfunction

  task automatic drive_reqs();
    req_valid = pend;
    req_op    = {p_op[1], p_op[0]};
    req_a     = {p_a[1], p_a[0]};
    req_b     = {p_b[1], p_b[0]};
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    pend[r] = 1'b1;
    p_op[r] = op;
    p_a[r]  = a;
    p_b[r]  = b;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom());
    endcase
  endfunction

  // Entered at a negedge with the DUT idle; returns with the DUT idle again at a negedge.
  task automatic serve_one(input int hold, output int g);
    logic [15:0] er;
    logic [4:0]  ef;
    int          el, lat;
    drive_reqs();
    #1;
    g = (pend == 2'b11) ? rr_m : (pend[1] ? 1 : 0);
    chk("grant", 32'(req_ready), 32'(2'b01 << g));
    model(p_op[g], p_a[g], p_b[g], er, ef, el);
    @(posedge clk);
    #1;
    pend[g] = 1'b0;
    rr_m = 1 - g;
    drive_reqs();
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid !== 1'b1) chk("busy_ready", 32'(req_ready), 32'h0);
    end
    chk("latency", 32'(lat), 32'(el));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_result", 32'(rsp_result), 32'(er));
    chk("rsp_flags", 32'(rsp_flags), 32'(ef));
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_result", 32'(rsp_result), 32'(er));
      chk("hold_flags", 32'(rsp_flags), 32'(ef));
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_release", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    pend      = 2'b00;
    rr_m      = 0;
    for (int r = 0; r < 2; r++) begin
      p_op[r] = 2'b00; p_a[r] = 16'h0; p_b[r] = 16'h0;
    end
    drive_reqs();
    req_valid = 2'b11;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_result", 32'(rsp_result), 32'h0);
    chk("rst_flags", 32'(rsp_flags), 32'h0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADD signed overflow from requester 0.
    set_req(0, 2'b00, 16'h7FFF, 16'h0001);
    serve_one(0, g);
    chk("add_result", 32'(rsp_result), 32'h8000);
    chk("add_flags", 32'(rsp_flags), 32'h14);
    chk("add_id", 32'(rsp_id), 32'h0);

    // SUB of equal operands from requester 1.
    set_req(1, 2'b01, 16'h0005, 16'h0005);
    serve_one(1, g);
    chk("sub_eq_result", 32'(rsp_result), 32'h0000);
    chk("sub_eq_flags", 32'(rsp_flags), 32'h0B);

    // SUB and CMP with signed overflow.
    set_req(0, 2'b01, 16'h8000, 16'h0001);
    serve_one(0, g);
    chk("sub_ov_result", 32'(rsp_result), 32'h7FFF);
    chk("sub_ov_flags", 32'(rsp_flags), 32'h18);
    set_req(0, 2'b10, 16'h8000, 16'h0001);
    serve_one(0, g);
    chk("cmp_result", 32'(rsp_result), 32'h8000);
    chk("cmp_flags", 32'(rsp_flags), 32'h18);

    // Back-pressure: five stalled RESP cycles, then one response only.
    set_req(1, 2'b11, 16'h1234, 16'hABCD);
    serve_one(5, g);
    chk("pass_result", 32'(rsp_result), 32'h1234);
    chk("pass_flags", 32'(rsp_flags), 32'h00);
    repeat (2) begin
      @(negedge clk);
      chk("no_extra_rsp", 32'(rsp_valid), 32'h0);
    end

    // Reset while a SUB sits in PASS2.
    set_req(1, 2'b01, 16'h0100, 16'h0003);
    drive_reqs();
    #1;
    chk("mid_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    pend = 2'b00;
    drive_reqs();
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_result", 32'(rsp_result), 32'h0);
    chk("mid_rst_flags", 32'(rsp_flags), 32'h0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(rsp_valid), 32'h0);
    end

    // Both requesters continuously valid: grants alternate from 0.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r]) set_req(r, 2'($urandom_range(0, 3)), pick(), pick());
      serve_one(0, g);
      chk("rr_seq", 32'(g), 32'(i % 2));
    end

    // Randomized traffic; the pending model keeps unserved requests asserted.
    for (int n = 0; n < 150; n++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 2) != 0)
          set_req(r, 2'($urandom_range(0, 3)), pick(), pick());
      if (pend == 2'b00) set_req(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick(), pick());
      serve_one(int'($urandom_range(0, 3)), g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_arbiter.md
ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, the operand/result width; only N=16 is supported, because the flag definitions use bit 15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have port req_valid, input, 2, per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_ready, output, 2, per-requester accept; at most one bit is high.
REQ-006 SHALL have port req_op, input, 4, packed opcodes; bits [2i+1:2i] belong to requester i.
REQ-007 SHALL have port req_a, input, 2N, packed operand A; bits [N*i+N-1:N*i] belong to requester i.
REQ-008 SHALL have port req_b, input, 2N, packed operand B, using the same packing as req_a.
REQ-009 SHALL have port rsp_valid, output, 1, response valid.
REQ-010 SHALL have port rsp_ready, input, 1, response consumer accept.
REQ-011 SHALL have port rsp_id, output, 1, index of the requester that owns the response.
REQ-012 SHALL have port rsp_result, output, N, the result.
REQ-013 SHALL have port rsp_flags, output, 5, the flags, ordered {V,C,N,Z,P}.

Function
REQ-014 SHALL decode opcodes as follows: 00 ADD (A+B); 01 SUB (A-B); 10 CMP (flags as SUB, rsp_result = A); 11 PASS (A+0).
REQ-015 SHALL share one ripple/CLA adder instance between both requesters; the adder has no carry-in.
REQ-016 SHALL implement an FSM with states IDLE, PASS1, PASS2 and RESP.
REQ-017 IDLE, grant: when any req_valid bit is high, SHALL grant by round-robin; the pointer is 0 after reset and moves to the non-granted requester after each grant.
REQ-018 IDLE, single requester: a lone valid requester SHALL be granted regardless of the pointer.
REQ-019 IDLE, accept: req_ready[g] SHALL be high combinationally only in IDLE and only for the granted g; the handshake captures op, A, B and id, then the FSM moves to PASS1.
REQ-020 PASS1 SHALL drive the adder with (A, B) for ADD, (A, ~B) for SUB/CMP, and (A, 0) for PASS, registering the sum as acc and the carry as c1.
REQ-021 From PASS1, ADD and PASS SHALL go to RESP and SUB/CMP SHALL go to PASS2.
REQ-022 PASS2 SHALL drive the adder with (acc, 16'h0001), register the sum as acc and the carry as c2, then go to RESP.
REQ-023 Flags for ADD/PASS SHALL be the adder's flags from PASS1.
REQ-024 SUB/CMP flags: C SHALL equal c1|c2 (1 = no borrow).
REQ-025 SUB/CMP flags: V SHALL equal (A[15]^B[15]) & (acc[15]^A[15]).
REQ-026 SUB/CMP flags: N, Z and P SHALL be derived from the final acc, with P = 1 for even parity.
REQ-027 RESP SHALL hold rsp_valid high with rsp_result, rsp_flags and rsp_id stable until rsp_ready is high, then return to IDLE.
REQ-028 Latency: rsp_valid SHALL rise 2 clock edges after the accept edge for ADD/PASS and 3 edges after for SUB/CMP.
REQ-029 Throughput: at most one operation SHALL be in flight; no new request is accepted until the RESP handshake completes, and IDLE is always re-entered for at least one cycle.
REQ-030 Requests held pending during a busy period SHALL remain pending; requesters keep req_valid high, and none is dropped or reordered.

Reset
REQ-031 On rst_n low, the FSM SHALL go to IDLE, the round-robin pointer to 0, acc to 0 and c1/c2 to 0.
REQ-032 On rst_n low, outputs SHALL be rsp_valid=0, req_ready=00, rsp_id=0, rsp_result=0 and rsp_flags=0.
REQ-033 Reset during PASS1, PASS2 or RESP SHALL abandon the operation with no response emitted.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the FSM state encoding and the flag bit indices (V=4, C=3, N=2, Z=1, P=0).
REQ-035 The existing 16-bit carry-look-ahead adder SHALL be instantiated as the only sub-module.

Verification
REQ-036 ADD: requester 0 sends 0x7FFF+0x0001 -> rsp_result 0x8000, flags 10100, rsp_id 0, rsp_valid 2 edges after the accept.
REQ-037 SUB equal operands: 0x0005-0x0005 -> pass1 0xFFFF (c1=0), pass2 0x0000 (c2=1) -> rsp_result 0x0000, flags 01011, 3-edge latency.
REQ-038 SUB signed overflow: 0x8000-0x0001 -> rsp_result 0x7FFF, flags 11000; CMP with the same operands -> rsp_result 0x8000, flags 11000.
REQ-039 Round-robin: both requesters valid continuously after reset -> grants alternate 0,1,0,1 with matching rsp_id; neither requester is starved.
REQ-040 Back-pressure: rsp_ready low for 5 cycles in RESP -> outputs stable, req_ready=00, then exactly one response on release.
REQ-041 Mid-operation reset: rst_n pulsed low during PASS2 -> rsp_valid never rises for that request, all outputs zero, and the next request is served normally with grant to requester 0.
